// File: rtl/wb_grf.sv
// wb_grf: writeback stage of the 5-stage MIPS core.
// Decodes the W-stage instruction into a destination register and writeback
// data, writes the 32x32 GPR file and serves the two D-stage read ports with
// a same-cycle W-to-D bypass.
// Optional build macro: GRF_TRACE_EN (prints every committed GPR write).
module wb_grf #(
  parameter int NREG   = 32,
  parameter int RA_IDX = 31
) (
  input  logic        clk,
  input  logic        rst,     // asynchronous, active-low
  input  logic [31:0] W_PC,
  input  logic [31:0] W_IR,
  input  logic [31:0] W_DMRD,
  input  logic [31:0] W_ALUO,
  input  logic [31:0] W_PC8,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic        W_WE
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic [31:0] gpr_q [NREG];
  logic [31:0] gpr_d [NREG];

  // PC is only needed by the trace; rs/shamt fields never affect writeback.
  logic unused_bits;
  assign unused_bits = ^{W_PC, W_IR[25:21], W_IR[10:6]};

  assign op    = W_IR[31:26];
  assign funct = W_IR[5:0];

  // Decode destination register and writeback data source.
  always_comb begin
    a3 = 5'd0;
    wd = W_ALUO;
    case (op)
      OP_SPECIAL: begin
        if (funct inside {6'h20, 6'h21, 6'h22, 6'h23}) a3 = W_IR[15:11];
      end
      OP_ORI, OP_LUI: a3 = W_IR[20:16];
      OP_LW: begin
        a3 = W_IR[20:16];
        wd = W_DMRD;
      end
      OP_JAL: begin
        a3 = 5'(RA_IDX);
        wd = W_PC8;
      end
      default: a3 = 5'd0;
    endcase
  end

  // A decoded target of $0 already yields a3 == 0, so no separate masking.
  assign W_A3 = a3;
  assign W_WD = wd;
  assign W_WE = (a3 != 5'd0);

  // Next register file contents: at most one entry replaced per cycle.
  always_comb begin
    for (int i = 0; i < NREG; i++) gpr_d[i] = gpr_q[i];
    if (W_WE) gpr_d[W_A3] = W_WD;
  end

  // Register file state; asynchronous clear holds everything at 0 while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  // Combinational read ports with $0 hardwired and W-to-D bypass.
  always_comb begin
    if (D_A1 == 5'd0)                 D_RD1 = '0;
    else if (W_WE && (D_A1 == W_A3))  D_RD1 = W_WD;
    else                              D_RD1 = gpr_q[D_A1];

    if (D_A2 == 5'd0)                 D_RD2 = '0;
    else if (W_WE && (D_A2 == W_A3))  D_RD2 = W_WD;
    else                              D_RD2 = gpr_q[D_A2];
  end

`ifdef GRF_TRACE_EN
  // Trace every committed write; W_WE excludes $0 by construction.
  always @(posedge clk) begin
    if (rst && W_WE) $display("@%08h: $%2d <= %08h", W_PC, W_A3, W_WD);
  end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed plus randomized checks of wb_grf against a behavioural
// register-file model held in the bench.
module tb_wb_grf;

  logic        clk;
  logic        rst;
  logic [31:0] W_PC, W_IR, W_DMRD, W_ALUO, W_PC8;
  logic [4:0]  D_A1, D_A2;
  logic [31:0] D_RD1, D_RD2, W_WD;
  logic [4:0]  W_A3;
  logic        W_WE;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  wb_grf dut (
    .clk(clk), .rst(rst), .W_PC(W_PC), .W_IR(W_IR), .W_DMRD(W_DMRD),
    .W_ALUO(W_ALUO), .W_PC8(W_PC8), .D_A1(D_A1), .D_A2(D_A2),
    .D_RD1(D_RD1), .D_RD2(D_RD2), .W_A3(W_A3), .W_WD(W_WD), .W_WE(W_WE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Destination register chosen by the instruction word.
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00 && fn >= 6'h20 && fn <= 6'h23) return ir[15:11];
    if (op == 6'h0d || op == 6'h0f || op == 6'h23) return ir[20:16];
    if (op == 6'h03) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] ir, input logic [31:0] dm,
                                          input logic [31:0] alu, input logic [31:0] pc8);
    if (ir[31:26] == 6'h23) return dm;
    if (ir[31:26] == 6'h03) return pc8;
    return alu;
  endfunction

  function automatic logic [31:0] read_of(input logic [4:0] a);
    logic [4:0] t;
    t = dest_of(W_IR);
    if (a == 5'd0) return 32'h0;
    if (t != 5'd0 && a == t) return data_of(W_IR, W_DMRD, W_ALUO, W_PC8);
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one W-stage instruction and read addresses, then check all outputs.
  task automatic apply(input logic [31:0] ir, input logic [31:0] dm, input logic [31:0] alu,
                       input logic [31:0] pc8, input logic [4:0] a1, input logic [4:0] a2);
    logic [4:0] t;
    W_IR = ir; W_DMRD = dm; W_ALUO = alu; W_PC8 = pc8; D_A1 = a1; D_A2 = a2;
    W_PC = W_PC + 32'd4;
    #1;
    t = dest_of(ir);
    chk("w_a3", {27'h0, W_A3}, {27'h0, t});
    chk("w_we", {31'h0, W_WE}, {31'h0, (t != 5'd0)});
    chk("w_wd", W_WD, data_of(ir, dm, alu, pc8));
    chk("d_rd1", D_RD1, read_of(a1));
    chk("d_rd2", D_RD2, read_of(a2));
    $display("step pc=%08h ir=%08h a3=%0d wd=%08h a1=%0d rd1=%08h a2=%0d rd2=%08h",
             W_PC, ir, W_A3, W_WD, a1, D_RD1, a2, D_RD2);
  endtask

  // Clock edge: commit into the model if the write is allowed.
  task automatic tick();
    logic [4:0]  t;
    logic [31:0] d;
    t = dest_of(W_IR);
    d = data_of(W_IR, W_DMRD, W_ALUO, W_PC8);
    @(posedge clk);
    if (rst && t != 5'd0) model[t] = d;
    #1;
  endtask

  initial begin
    logic [31:0] ir;
    logic [31:0] v;
    logic [4:0]  a1, a2;
    int kind;

    rst = 1'b0;
    W_PC = 32'h00003000; W_IR = '0; W_DMRD = '0; W_ALUO = '0; W_PC8 = '0;
    D_A1 = 5'd0; D_A2 = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    chk("reset_rd1", D_RD1, 32'h0);
    rst = 1'b1;
    tick();

    // ori $5,$0,0x1234
    apply(32'h34051234, 32'h0, 32'h00001234, 32'h0, 5'd5, 5'd0);
    chk("ori_a3", {27'h0, W_A3}, 32'd5);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
    chk("ori_rd", D_RD1, 32'h00001234);
    tick();

    // lw $7 then sw with same fields
    apply(32'h8C070010, 32'hDEADBEEF, 32'h00000010, 32'h0, 5'd7, 5'd0);
    tick();
    apply(32'hAC070010, 32'h12345678, 32'h00000010, 32'h0, 5'd7, 5'd7);
    chk("sw_we", {31'h0, W_WE}, 32'd0);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0);
    chk("lw_rd", D_RD1, 32'hDEADBEEF);
    tick();

    // jal then jr $31
    apply(32'h0C000C00, 32'h0, 32'h55555555, 32'h00003008, 5'd31, 5'd0);
    tick();
    apply(32'h03E00008, 32'h0, 32'h0, 32'h0, 5'd31, 5'd0);
    chk("jr_a3", {27'h0, W_A3}, 32'd0);
    chk("jal_rd", D_RD1, 32'h00003008);
    tick();

    // addu $0,$1,$2 is dropped
    apply(32'h00220021, 32'h0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    chk("zero_we", {31'h0, W_WE}, 32'd0);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    chk("zero_rd", D_RD1, 32'h0);
    tick();

    // Same-cycle bypass on both ports
    apply(32'h34030011, 32'h0, 32'h00000011, 32'h0, 5'd0, 5'd0);
    tick();
    apply(32'h00221821, 32'h0, 32'h00000022, 32'h0, 5'd3, 5'd3);
    chk("byp_rd1", D_RD1, 32'h00000022);
    chk("byp_rd2", D_RD2, 32'h00000022);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
    chk("byp_after", D_RD1, 32'h00000022);
    tick();

    // Randomized instruction mix
    for (int n = 0; n < 300; n++) begin
      ir = $urandom;
      kind = $urandom_range(0, 7);
      case (kind)
        0: ir = {6'h00, ir[25:6], 6'(6'h20 + 6'($urandom_range(0, 3)))};
        1: ir[31:26] = 6'h0d;
        2: ir[31:26] = 6'h0f;
        3: ir[31:26] = 6'h23;
        4: ir[31:26] = 6'h03;
        5: ir[31:26] = 6'h2b;
        6: ir[31:26] = 6'h04;
        default: ;
      endcase
      a1 = 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
      if ($urandom_range(0, 2) == 0) a1 = dest_of(ir);
      apply(ir, $urandom, $urandom, $urandom, a1, a2);
      tick();
    end

    // Populate $1..$4, then drop reset mid-cycle
    for (int r = 1; r <= 4; r++) begin
      v = $urandom | 32'h1;
      ir = {6'h0d, 5'd0, 5'(r), 16'h0};
      apply(ir, 32'h0, v, 32'h0, 5'd0, 5'd0);
      tick();
    end
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd4);
    chk("pre_rst_rd1", D_RD1, model[1]);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    chk("rst_rd1", D_RD1, 32'h0);
    chk("rst_rd2", D_RD2, 32'h0);
    // Write attempted under reset: bypass visible, nothing committed
    apply(32'h34060000, 32'h0, 32'hCAFEF00D, 32'h0, 5'd6, 5'd2);
    chk("rst_byp", D_RD1, 32'hCAFEF00D);
    tick();
    #2 rst = 1'b1;
    #1;
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd6, 5'd3);
    chk("rst_nocommit", D_RD1, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
